phy_conf_seq: RTL and testbench

- Parametrised successor to the single-write MII-control configurator.
- Walks a table of NUM_REGS {register address, data} entries and writes each one to one PHY through the MDIO master handshake (wren/rden/busy).
- With VERIFY enabled, reads each register back, compares it under a mask, and retries the write on mismatch. A timeout guards every transaction.
- Sits between board bring-up logic and the MDIO master. It can be re-run without a reset.

---
 rtl/phy_conf_seq.sv | 228 ++++++++++++++++++++++
 tb/tb_phy_conf_seq.sv | 489 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/phy_conf_seq.sv
// PHY configuration sequencer: writes a {reg, data} table to one PHY through an
// MDIO master handshake, optionally reading each entry back and retrying on mismatch.
module phy_conf_seq #(
    parameter int unsigned            NUM_REGS    = 4,
    parameter int unsigned            IDXW        = 4,
    parameter logic [4:0]             PHY_ADDR    = 5'h0F,
    parameter logic [21*NUM_REGS-1:0] CFG_TABLE   = {5'h00, 16'h1300, 5'h09, 16'h0000,
                                                     5'h04, 16'h01E1, 5'h00, 16'h1100},
    parameter bit                     VERIFY      = 1'b1,
    parameter logic [15:0]            VERIFY_MASK = 16'h7DFF,
    parameter int unsigned            MAX_RETRY   = 3,
    parameter int unsigned            TIMEOUT     = 1023
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_conf,
    input  logic            busy,
    input  logic [15:0]     rd_data,
    input  logic            rd_valid,
    output logic [4:0]      phy_add_o,
    output logic [4:0]      reg_add,
    output logic [15:0]     wr_data,
    output logic            wren,
    output logic            rden,
    output logic            active,
    output logic            conf_done,
    output logic            conf_err,
    output logic [IDXW-1:0] err_idx
);
    localparam int unsigned EW = 21;
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    typedef enum logic [3:0] {
        S_IDLE, S_WR_REQ, S_WR_ACK, S_WR_DONE, S_RD_REQ, S_RD_ACK,
        S_RD_DONE, S_CHECK, S_NEXT, S_DONE, S_ERROR
    } state_t;

    state_t          state_q, state_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic [RW-1:0]   retry_q, retry_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [4:0]      phy_q, phy_d;
    logic [4:0]      reg_q, reg_d;
    logic [15:0]     wdat_q, wdat_d;
    logic            wren_q, wren_d;
    logic            rden_q, rden_d;
    logic            active_q, active_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic [IDXW-1:0] eidx_q, eidx_d;
    logic [15:0]     rdat_q, rdat_d;
    logic            rseen_q, rseen_d;
    logic            to_err;

    logic [EW-1:0]   entry_c;
    logic            timeout_c;
    logic            last_c;
    logic            retry_ok_c;
    logic            pass_c;

    // Table lookup for the current entry; index values past NUM_REGS read as zero.
    always_comb begin
        entry_c = '0;
        for (int i = 0; i < int'(NUM_REGS); i++) begin
            if (idx_q == IDXW'(i)) entry_c = CFG_TABLE[i*EW +: EW];
        end
    end

    assign timeout_c  = (timer_q == TW'(TIMEOUT - 1));
    assign last_c     = (idx_q == IDXW'(NUM_REGS - 1));
    assign retry_ok_c = (retry_q < RW'(MAX_RETRY));
    assign pass_c     = rseen_q && ((rdat_q & VERIFY_MASK) == (entry_c[15:0] & VERIFY_MASK));

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        retry_d  = retry_q;
        phy_d    = phy_q;
        reg_d    = reg_q;
        wdat_d   = wdat_q;
        wren_d   = 1'b0;
        rden_d   = 1'b0;
        active_d = active_q;
        done_d   = done_q;
        err_d    = err_q;
        eidx_d   = eidx_q;
        rdat_d   = rdat_q;
        rseen_d  = rseen_q;
        to_err   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_conf) begin
                    done_d   = 1'b0;
                    err_d    = 1'b0;
                    eidx_d   = '0;
                    active_d = 1'b1;
                    idx_d    = '0;
                    retry_d  = '0;
                    state_d  = S_WR_REQ;
                end
            end
            S_WR_REQ: begin
                if (!busy) begin
                    wren_d  = 1'b1;
                    phy_d   = PHY_ADDR;
                    reg_d   = entry_c[20:16];
                    wdat_d  = entry_c[15:0];
                    state_d = S_WR_ACK;
                end
            end
            S_WR_ACK: begin
                if (busy)           state_d = S_WR_DONE;
                else if (timeout_c) to_err  = 1'b1;
            end
            S_WR_DONE: begin
                if (!busy)          state_d = VERIFY ? S_RD_REQ : S_NEXT;
                else if (timeout_c) to_err  = 1'b1;
            end
            S_RD_REQ: begin
                if (!busy) begin
                    rden_d  = 1'b1;
                    rseen_d = 1'b0;
                    phy_d   = PHY_ADDR;
                    reg_d   = entry_c[20:16];
                    state_d = S_RD_ACK;
                end
            end
            S_RD_ACK: begin
                if (busy)           state_d = S_RD_DONE;
                else if (timeout_c) to_err  = 1'b1;
            end
            S_RD_DONE: begin
                if (!busy)          state_d = S_CHECK;
                else if (timeout_c) to_err  = 1'b1;
            end
            S_CHECK: begin
                if (pass_c) begin
                    state_d = S_NEXT;
                end else if (retry_ok_c) begin
                    retry_d = retry_q + RW'(1);
                    state_d = S_WR_REQ;
                end else begin
                    to_err = 1'b1;
                end
            end
            S_NEXT: begin
                retry_d = '0;
                if (last_c) begin
                    done_d   = 1'b1;
                    active_d = 1'b0;
                    state_d  = S_DONE;
                end else begin
                    idx_d   = idx_q + IDXW'(1);
                    state_d = S_WR_REQ;
                end
            end
            S_DONE, S_ERROR: begin
                if (!start_conf) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Abort path shared by every timeout and by exhausted retries.
        if (to_err) begin
            err_d    = 1'b1;
            eidx_d   = idx_q;
            active_d = 1'b0;
            state_d  = S_ERROR;
        end

        // Read data may arrive any time during the read's busy window.
        if ((state_q == S_RD_ACK || state_q == S_RD_DONE) && rd_valid) begin
            rdat_d  = rd_data;
            rseen_d = 1'b1;
        end

        timer_d = (state_d != state_q) ? '0 : timer_q + TW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            retry_q  <= '0;
            timer_q  <= '0;
            phy_q    <= '0;
            reg_q    <= '0;
            wdat_q   <= '0;
            wren_q   <= 1'b0;
            rden_q   <= 1'b0;
            active_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            eidx_q   <= '0;
            rdat_q   <= '0;
            rseen_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            retry_q  <= retry_d;
            timer_q  <= timer_d;
            phy_q    <= phy_d;
            reg_q    <= reg_d;
            wdat_q   <= wdat_d;
            wren_q   <= wren_d;
            rden_q   <= rden_d;
            active_q <= active_d;
            done_q   <= done_d;
            err_q    <= err_d;
            eidx_q   <= eidx_d;
            rdat_q   <= rdat_d;
            rseen_q  <= rseen_d;
        end
    end

    assign phy_add_o = phy_q;
    assign reg_add   = reg_q;
    assign wr_data   = wdat_q;
    assign wren      = wren_q;
    assign rden      = rden_q;
    assign active    = active_q;
    assign conf_done = done_q;
    assign conf_err  = err_q;
    assign err_idx   = eidx_q;

endmodule

// File: tb/tb_phy_conf_seq.sv
// Bench for phy_conf_seq: a verifying and a write-only instance, each driven by a
// small MDIO master model, checked against a table-walking reference model.
module tb_phy_conf_seq;
    localparam int          N    = 4;
    localparam int          MAXR = 3;
    localparam int          TMO  = 15;
    localparam logic [15:0] MASK = 16'h7DFF;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        start_w [2];
    logic        busy_w  [2];
    logic        rdv_w   [2];
    logic [15:0] rdd_w   [2];
    logic [4:0]  phy_w   [2];
    logic [4:0]  reg_w   [2];
    logic [15:0] wd_w    [2];
    logic        wren_w  [2];
    logic        rden_w  [2];
    logic        act_w   [2];
    logic        done_w  [2];
    logic        err_w   [2];
    logic [3:0]  eidx_w  [2];

    logic        force_busy [2];
    logic        hang       [2];
    logic [4:0]  bad_reg    [2];
    int          bad_n      [2];
    logic [15:0] bad_xor    [2];
    int          blen_max;

    logic [4:0]  tbl_reg [N] = '{5'h00, 5'h04, 5'h09, 5'h00};
    logic [15:0] tbl_dat [N] = '{16'h1100, 16'h01E1, 16'h0000, 16'h1300};

    logic [21:0] log0 [$];
    logic [21:0] log1 [$];
    logic [21:0] exp_q [$];
    bit          exp_err;
    logic [3:0]  exp_idx;

    int n_checks = 0;
    int n_errs   = 0;
    int phy_bad  = 0;
    int both_bad = 0;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        phy_conf_seq #(.VERIFY(g == 0), .TIMEOUT(TMO)) u_dut (
            .clk(clk), .rst(rst), .start_conf(start_w[g]), .busy(busy_w[g]),
            .rd_data(rdd_w[g]), .rd_valid(rdv_w[g]), .phy_add_o(phy_w[g]),
            .reg_add(reg_w[g]), .wr_data(wd_w[g]), .wren(wren_w[g]), .rden(rden_w[g]),
            .active(act_w[g]), .conf_done(done_w[g]), .conf_err(err_w[g]),
            .err_idx(eidx_w[g])
        );

        // MDIO master model: random busy length, echoes writes, optional corrupted reads.
        logic        mbusy, mrdv, is_rd, start_q;
        logic [15:0] mrdd;
        logic [4:0]  ra;
        int          cnt, nbad;
        logic [15:0] mem [32];

        assign busy_w[g] = mbusy | force_busy[g];
        assign rdv_w[g]  = mrdv;
        assign rdd_w[g]  = mrdd;

        always @(posedge clk or posedge rst) begin
            if (rst) begin
                mbusy <= 1'b0; mrdv <= 1'b0; is_rd <= 1'b0; start_q <= 1'b0;
                mrdd <= 16'h0; ra <= 5'h0; cnt <= 0; nbad <= 0;
            end else begin
                start_q <= start_w[g];
                if (start_w[g] && !start_q) nbad <= 0;
                mrdv <= 1'b0;
                if (cnt > 0) begin
                    cnt <= cnt - 1;
                    if (cnt == 1) begin
                        mbusy <= 1'b0;
                        if (is_rd) begin
                            mrdv <= 1'b1;
                            if (ra == bad_reg[g] && nbad < bad_n[g]) begin
                                mrdd <= mem[ra] ^ bad_xor[g];
                                nbad <= nbad + 1;
                            end else begin
                                mrdd <= mem[ra];
                            end
                        end
                    end
                end else if ((wren_w[g] || rden_w[g]) && !hang[g]) begin
                    mbusy <= 1'b1;
                    cnt   <= int'($urandom_range(32'(blen_max), 1));
                    is_rd <= rden_w[g];
                    ra    <= reg_w[g];
                    if (wren_w[g]) mem[reg_w[g]] <= wd_w[g];
                end
            end
        end
    end

    // Transaction monitor: {is_read, reg, write data (0 for reads)}.
    always @(negedge clk) begin
        if (wren_w[0] || rden_w[0]) begin
            log0.push_back({rden_w[0], reg_w[0], wren_w[0] ? wd_w[0] : 16'h0});
            if (phy_w[0] !== 5'h0F) phy_bad++;
        end
        if (wren_w[1] || rden_w[1]) begin
            log1.push_back({rden_w[1], reg_w[1], wren_w[1] ? wd_w[1] : 16'h0});
            if (phy_w[1] !== 5'h0F) phy_bad++;
        end
        if (wren_w[0] && rden_w[0]) both_bad++;
        if (wren_w[1] && rden_w[1]) both_bad++;
    end

    // Reference: walk the table, each attempt is a write plus (optionally) a read whose
    // value is corrupted by bx for the first bn reads of register breg.
    task automatic ref_model(input bit verify, input logic [4:0] breg, input int bn,
                             input logic [15:0] bx);
        int left;
        bit ok;
        logic [15:0] rv;
        exp_q.delete();
        exp_err = 1'b0;
        exp_idx = 4'h0;
        left    = bn;
        for (int i = 0; i < N; i++) begin
            ok = 1'b0;
            for (int a = 0; a <= MAXR && !ok; a++) begin
                exp_q.push_back({1'b0, tbl_reg[i], tbl_dat[i]});
                if (!verify) begin
                    ok = 1'b1;
                end else begin
                    exp_q.push_back({1'b1, tbl_reg[i], 16'h0});
                    rv = tbl_dat[i];
                    if (tbl_reg[i] == breg && left > 0) begin
                        rv = rv ^ bx;
                        left--;
                    end
                    ok = ((rv & MASK) == (tbl_dat[i] & MASK));
                end
            end
            if (!ok) begin
                exp_err = 1'b1;
                exp_idx = 4'(i);
                return;
            end
        end
    endtask

    function automatic int log_diff(input int g);
        logic [21:0] e;
        int n = (g == 0) ? log0.size() : log1.size();
        for (int i = 0; i < n && i < exp_q.size(); i++) begin
            e = (g == 0) ? log0[i] : log1[i];
            if (e !== exp_q[i]) return i;
        end
        if (n != exp_q.size()) return (n < exp_q.size()) ? n : exp_q.size();
        return -1;
    endfunction

    task automatic wait_end(input int g, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            if (done_w[g] || err_w[g]) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic rearm(input int g);
        @(negedge clk); start_w[g] = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int g = 0; g < 2; g++) begin
            n_checks++;
            if ({wren_w[g], rden_w[g], act_w[g], done_w[g], err_w[g]} !== 5'b0) begin
                n_errs++;
                $display("FAIL reset_ctl[%0d] got=%b exp=00000", g,
                         {wren_w[g], rden_w[g], act_w[g], done_w[g], err_w[g]});
            end
            n_checks++;
            if ({phy_w[g], reg_w[g], wd_w[g], eidx_w[g]} !== 30'h0) begin
                n_errs++;
                $display("FAIL reset_bus[%0d] got=%h exp=0", g,
                         {phy_w[g], reg_w[g], wd_w[g], eidx_w[g]});
            end
        end
        @(negedge clk) rst = 1'b0;
    endtask

    task automatic test_default;
        bit ok;
        int d;
        blen_max = 2;
        ref_model(1'b1, 5'h1F, 0, 16'h0);
        log0.delete();
        @(negedge clk) start_w[0] = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (wren_w[0] !== 1'b0 || act_w[0] !== 1'b1) begin
            n_errs++;
            $display("FAIL start_edge got wren=%b active=%b exp wren=0 active=1", wren_w[0], act_w[0]);
        end
        @(posedge clk); #1;
        n_checks++;
        if ({wren_w[0], phy_w[0], reg_w[0], wd_w[0]} !== {1'b1, 5'h0F, 5'h00, 16'h1100}) begin
            n_errs++;
            $display("FAIL first_wren got wren=%b phy=%h reg=%h data=%h exp 1 0f 00 1100",
                     wren_w[0], phy_w[0], reg_w[0], wd_w[0]);
        end
        wait_end(0, ok);
        n_checks++;
        if (!ok) begin n_errs++; $display("FAIL default_timeout got=no_end exp=end"); end
        n_checks++;
        if ({done_w[0], err_w[0], act_w[0]} !== 3'b100) begin
            n_errs++;
            $display("FAIL default_flags got=%b exp=100", {done_w[0], err_w[0], act_w[0]});
        end
        d = log_diff(0);
        n_checks++;
        if (d != -1) begin
            n_errs++;
            $display("FAIL default_log diff_at=%0d got_size=%0d exp_size=%0d", d, log0.size(), exp_q.size());
        end
    endtask

    task automatic test_verify_fail;
        bit ok;
        int d, n04, n09;
        rearm(0);
        bad_reg[0] = 5'h04; bad_n[0] = 1000; bad_xor[0] = 16'h0001;
        ref_model(1'b1, 5'h04, 1000, 16'h0001);
        log0.delete();
        @(negedge clk) start_w[0] = 1'b1;
        wait_end(0, ok);
        n_checks++;
        if (!ok) begin n_errs++; $display("FAIL vfail_timeout got=no_end exp=end"); end
        n_checks++;
        if ({done_w[0], err_w[0], eidx_w[0]} !== {1'b0, 1'b1, 4'd1}) begin
            n_errs++;
            $display("FAIL vfail_flags got done=%b err=%b idx=%0d exp 0 1 1", done_w[0], err_w[0], eidx_w[0]);
        end
        n04 = 0; n09 = 0;
        foreach (log0[i]) begin
            if (log0[i][21] == 1'b0 && log0[i][20:16] == 5'h04) n04++;
            if (log0[i][20:16] == 5'h09) n09++;
        end
        n_checks++;
        if (n04 != 4 || n09 != 0) begin
            n_errs++;
            $display("FAIL vfail_counts got wr04=%0d acc09=%0d exp 4 0", n04, n09);
        end
        d = log_diff(0);
        n_checks++;
        if (d != -1) begin
            n_errs++;
            $display("FAIL vfail_log diff_at=%0d got_size=%0d exp_size=%0d", d, log0.size(), exp_q.size());
        end
        bad_n[0] = 0;
    endtask

    task automatic test_busy_hold;
        bit ok, saw;
        int d, nrd;
        for (int g = 0; g < 2; g++) begin
            rearm(g);
            ref_model(g == 0, 5'h1F, 0, 16'h0);
            if (g == 0) log0.delete(); else log1.delete();
            force_busy[g] = 1'b1;
            start_w[g] = 1'b1;
            saw = 1'b0;
            repeat (20) begin
                @(posedge clk); #1;
                if (wren_w[g]) saw = 1'b1;
            end
            n_checks++;
            if (saw || err_w[g] !== 1'b0 || eidx_w[g] !== 4'd0 || act_w[g] !== 1'b1) begin
                n_errs++;
                $display("FAIL hold[%0d] got wren_seen=%b err=%b idx=%0d active=%b exp 0 0 0 1",
                         g, saw, err_w[g], eidx_w[g], act_w[g]);
            end
            @(negedge clk) force_busy[g] = 1'b0;
            @(posedge clk); #1;
            n_checks++;
            if (wren_w[g] !== 1'b1) begin
                n_errs++;
                $display("FAIL hold_release[%0d] got wren=%b exp=1", g, wren_w[g]);
            end
            wait_end(g, ok);
            n_checks++;
            if (!ok || done_w[g] !== 1'b1) begin
                n_errs++;
                $display("FAIL hold_done[%0d] got ended=%b done=%b exp 1 1", g, ok, done_w[g]);
            end
            d = log_diff(g);
            n_checks++;
            if (d != -1) begin
                n_errs++;
                $display("FAIL hold_log[%0d] diff_at=%0d exp_size=%0d", g, d, exp_q.size());
            end
        end
        nrd = 0;
        foreach (log1[i]) if (log1[i][21]) nrd++;
        n_checks++;
        if (nrd != 0) begin n_errs++; $display("FAIL noverify_reads got=%0d exp=0", nrd); end
        @(negedge clk) start_w[1] = 1'b0;
    endtask

    task automatic test_random;
        bit ok;
        int d, b;
        logic [4:0] regs [4] = '{5'h00, 5'h04, 5'h09, 5'h03};
        for (int it = 0; it < 8; it++) begin
            rearm(0);
            blen_max = int'($urandom_range(4, 1));
            bad_reg[0] = regs[$urandom_range(3, 0)];
            bad_n[0] = int'($urandom_range(5, 0));
            b = int'($urandom_range(13, 0));
            if (b >= 9) b++;
            case ($urandom_range(2, 0))
                0:       bad_xor[0] = 16'(1) << b;
                1:       bad_xor[0] = 16'h8200;
                default: bad_xor[0] = ($urandom_range(1, 0) != 0) ? 16'h8000 : 16'h0200;
            endcase
            ref_model(1'b1, bad_reg[0], bad_n[0], bad_xor[0]);
            log0.delete();
            @(negedge clk) start_w[0] = 1'b1;
            wait_end(0, ok);
            n_checks++;
            if (!ok || {done_w[0], err_w[0]} !== {~exp_err, exp_err} ||
                (exp_err && eidx_w[0] !== exp_idx)) begin
                n_errs++;
                $display("FAIL rand%0d_flags got done=%b err=%b idx=%0d exp err=%b idx=%0d",
                         it, done_w[0], err_w[0], eidx_w[0], exp_err, exp_idx);
            end
            d = log_diff(0);
            n_checks++;
            if (d != -1) begin
                n_errs++;
                $display("FAIL rand%0d_log diff_at=%0d got_size=%0d exp_size=%0d",
                         it, d, log0.size(), exp_q.size());
            end
        end
        bad_n[0] = 0;
        blen_max = 2;
    endtask

    task automatic test_timeout;
        bit seen;
        int n;
        rearm(0);
        hang[0] = 1'b1;
        start_w[0] = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(posedge clk); #1;
            if (wren_w[0]) seen = 1'b1;
        end
        n = 0;
        if (seen) begin
            for (int c = 1; c <= 40; c++) begin
                @(posedge clk); #1;
                if (err_w[0]) begin n = c; break; end
            end
        end
        n_checks++;
        if (n != TMO) begin
            n_errs++;
            $display("FAIL timeout_cycles got=%0d exp=%0d (wren_seen=%b)", n, TMO, seen);
        end
        n_checks++;
        if ({eidx_w[0], act_w[0], done_w[0]} !== 6'b0) begin
            n_errs++;
            $display("FAIL timeout_flags got idx=%0d active=%b done=%b exp 0 0 0",
                     eidx_w[0], act_w[0], done_w[0]);
        end
        hang[0] = 1'b0;
    endtask

    task automatic test_reset_mid;
        bit ok;
        int nw, d;
        rearm(0);
        ref_model(1'b1, 5'h1F, 0, 16'h0);
        start_w[0] = 1'b1;
        nw = 0;
        for (int c = 0; c < 200 && nw < 2; c++) begin
            @(posedge clk); #1;
            if (wren_w[0]) nw++;
        end
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (nw != 2 || {wren_w[0], rden_w[0], act_w[0], done_w[0], err_w[0],
                        phy_w[0], reg_w[0], wd_w[0], eidx_w[0]} !== 35'h0) begin
            n_errs++;
            $display("FAIL async_reset got wr_seen=%0d outs=%h exp 2 0", nw,
                     {wren_w[0], rden_w[0], act_w[0], done_w[0], err_w[0],
                      phy_w[0], reg_w[0], wd_w[0], eidx_w[0]});
        end
        log0.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wait_end(0, ok);
        n_checks++;
        if (!ok || done_w[0] !== 1'b1 || log0.size() == 0 || log0[0] !== {1'b0, 5'h00, 16'h1100}) begin
            n_errs++;
            $display("FAIL restart got ended=%b done=%b first=%h exp 1 1 %h", ok, done_w[0],
                     (log0.size() > 0) ? log0[0] : 22'h0, {1'b0, 5'h00, 16'h1100});
        end
        d = log_diff(0);
        n_checks++;
        if (d != -1) begin
            n_errs++;
            $display("FAIL restart_log diff_at=%0d got_size=%0d exp_size=%0d", d, log0.size(), exp_q.size());
        end
    endtask

    task automatic test_rearm;
        bit ok;
        int d;
        ref_model(1'b1, 5'h1F, 0, 16'h0);
        @(negedge clk) start_w[0] = 1'b0;
        @(posedge clk);
        @(negedge clk) start_w[0] = 1'b1;
        log0.delete();
        @(posedge clk); #1;
        n_checks++;
        if ({done_w[0], err_w[0], act_w[0]} !== 3'b001) begin
            n_errs++;
            $display("FAIL rearm_clear got done=%b err=%b active=%b exp 0 0 1", done_w[0], err_w[0], act_w[0]);
        end
        wait_end(0, ok);
        n_checks++;
        if (!ok || done_w[0] !== 1'b1 || err_w[0] !== 1'b0) begin
            n_errs++;
            $display("FAIL rearm_done got ended=%b done=%b err=%b exp 1 1 0", ok, done_w[0], err_w[0]);
        end
        d = log_diff(0);
        n_checks++;
        if (d != -1) begin
            n_errs++;
            $display("FAIL rearm_log diff_at=%0d got_size=%0d exp_size=%0d", d, log0.size(), exp_q.size());
        end
    endtask

    task automatic test_invariants;
        n_checks++;
        if (phy_bad != 0 || both_bad != 0) begin
            n_errs++;
            $display("FAIL invariants got phy_bad=%0d both_req=%0d exp 0 0", phy_bad, both_bad);
        end
    endtask

    initial begin
        for (int g = 0; g < 2; g++) begin
            start_w[g] = 1'b0; force_busy[g] = 1'b0; hang[g] = 1'b0;
            bad_reg[g] = 5'h1F; bad_n[g] = 0; bad_xor[g] = 16'h0;
        end
        blen_max = 2;
        test_reset();
        test_default();
        test_verify_fail();
        test_busy_hold();
        test_random();
        test_timeout();
        test_reset_mid();
        test_rearm();
        test_invariants();
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=no_finish exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
